// File: rtl/nwcc_pkg.sv
// Shared types and default widths for the neutron coincidence counter cycle sequencer.
package nwcc_pkg;

  localparam int DEF_DATA_BITS = 24;
  localparam int DEF_TIME_BITS = 24;
  localparam int DEF_CYC_BITS  = 8;

  // Longest shift-register delay in the datapath plus the pipeline slack behind it.
  localparam int LONGEST_DELAY = 1024;
  localparam int DRAIN_MARGIN  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_DRAIN,
    ST_LATCH,
    ST_WAIT_ACK
  } state_e;

endpackage

// File: rtl/nwcc_down_timer.sv
// Loadable down-counter that stops at zero; one instance times CLEAR, COUNT and DRAIN.
module nwcc_down_timer #(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/nwcc_cycle_ctrl.sv
// Measurement-cycle sequencer: clear, gated count, drain, latch and hand results to the reader.
module nwcc_cycle_ctrl
  import nwcc_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int TIME_BITS    = DEF_TIME_BITS,
  parameter int CYC_BITS     = DEF_CYC_BITS,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 1040
) (
  input  logic                 i_clk_1mhz,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [TIME_BITS-1:0] i_count_time,
  input  logic [CYC_BITS-1:0]  i_num_cycles,
  input  logic                 i_pulse_signal,
  output logic                 o_pulse_gated,
  output logic                 o_dp_reset,
  input  logic [DATA_BITS-1:0] i_r_plus_a_count,
  input  logic [DATA_BITS-1:0] i_a_count,
  input  logic [DATA_BITS-1:0] i_total_count,
  output logic [DATA_BITS-1:0] o_r_plus_a,
  output logic [DATA_BITS-1:0] o_a,
  output logic [DATA_BITS-1:0] o_total,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [CYC_BITS-1:0]  o_cycle_idx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int DRAIN_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int TMR_BITS = (TIME_BITS > DRAIN_W) ? TIME_BITS : DRAIN_W;

  if (DRAIN_CYCLES < LONGEST_DELAY + DRAIN_MARGIN) begin : g_bad_drain
    $error("DRAIN_CYCLES too short for the longest delay line");
  end
  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("CLEAR_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  logic [TIME_BITS-1:0] count_time_q, count_time_d;
  logic [CYC_BITS-1:0]  num_cycles_q, num_cycles_d;
  logic [CYC_BITS-1:0]  cycle_idx_q, cycle_idx_d;
  logic [DATA_BITS-1:0] r_plus_a_q, r_plus_a_d;
  logic [DATA_BITS-1:0] a_q, a_d;
  logic [DATA_BITS-1:0] total_q, total_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 dp_reset_q, dp_reset_d;
  logic                 tmr_load;
  logic [TMR_BITS-1:0]  tmr_val;
  logic                 tmr_zero;
  logic [CYC_BITS:0]    idx_next;

  nwcc_down_timer #(.WIDTH(TMR_BITS)) u_timer (
    .i_clk      (i_clk_1mhz),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero     (tmr_zero)
  );

  // One extra bit so the last-cycle test cannot wrap at the top of the index range.
  assign idx_next = {1'b0, cycle_idx_q} + (CYC_BITS + 1)'(1);

  always_comb begin
    state_d      = state_q;
    count_time_d = count_time_q;
    num_cycles_d = num_cycles_q;
    cycle_idx_d  = cycle_idx_q;
    r_plus_a_d   = r_plus_a_q;
    a_d          = a_q;
    total_d      = total_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    if (i_abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && (i_count_time != '0) && (i_num_cycles != '0)) begin
            count_time_d = i_count_time;
            num_cycles_d = i_num_cycles;
            cycle_idx_d  = '0;
            state_d      = ST_CLEAR;
            tmr_load     = 1'b1;
            tmr_val      = TMR_BITS'(CLEAR_CYCLES - 1);
          end
        end
        ST_CLEAR: begin
          if (tmr_zero) begin
            state_d  = ST_COUNT;
            tmr_load = 1'b1;
            tmr_val  = TMR_BITS'(count_time_q) - TMR_BITS'(1);
          end
        end
        ST_COUNT: begin
          if (tmr_zero) begin
            state_d  = ST_DRAIN;
            tmr_load = 1'b1;
            tmr_val  = TMR_BITS'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (tmr_zero) begin
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_plus_a_d = i_r_plus_a_count;
          a_d        = i_a_count;
          total_d    = i_total_count;
          valid_d    = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (i_ack && valid_q) begin
            valid_d = 1'b0;
            if (idx_next < {1'b0, num_cycles_q}) begin
              cycle_idx_d = idx_next[CYC_BITS-1:0];
              state_d     = ST_CLEAR;
              tmr_load    = 1'b1;
              tmr_val     = TMR_BITS'(CLEAR_CYCLES - 1);
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    dp_reset_d = (state_d == ST_CLEAR);
  end

  // The datapath reset is asserted throughout our own reset so the counters start clean.
  always_ff @(posedge i_clk_1mhz) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      count_time_q <= '0;
      num_cycles_q <= '0;
      cycle_idx_q  <= '0;
      r_plus_a_q   <= '0;
      a_q          <= '0;
      total_q      <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      dp_reset_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_time_q <= count_time_d;
      num_cycles_q <= num_cycles_d;
      cycle_idx_q  <= cycle_idx_d;
      r_plus_a_q   <= r_plus_a_d;
      a_q          <= a_d;
      total_q      <= total_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      dp_reset_q   <= dp_reset_d;
    end
  end

  assign o_pulse_gated = i_pulse_signal && (state_q == ST_COUNT);
  assign o_dp_reset    = dp_reset_q;
  assign o_r_plus_a    = r_plus_a_q;
  assign o_a           = a_q;
  assign o_total       = total_q;
  assign o_valid       = valid_q;
  assign o_cycle_idx   = cycle_idx_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;

endmodule
